// File: rtl/wishbone_slave_regfile.sv
// Wishbone slave register bank: RW control registers, RO status registers and a
// maskable, edge-triggered, write-1-to-clear interrupt controller with byte-lane writes.
module wishbone_slave_regfile #(
    parameter int DW       = 32,
    parameter int NUM_REGS = 4,
    parameter int NUM_INTS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [DW/8-1:0]        wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [DW-1:0]          wbs_dat_i,
    output logic [DW-1:0]          wbs_dat_o,
    output logic                   wbs_ack_o,
    output logic                   wbs_int_o,
    output logic [NUM_REGS*DW-1:0] ctrl_o,
    output logic [NUM_REGS-1:0]    wr_stb_o,
    input  logic [NUM_REGS*DW-1:0] stat_i,
    input  logic [NUM_INTS-1:0]    irq_i
);

    localparam int          NB             = DW / 8;
    localparam logic [31:0] ADR_INT_STATUS = 32'd0;
    localparam logic [31:0] ADR_INT_ENABLE = 32'd1;
    localparam logic [31:0] ADR_CTRL_BASE  = 32'd2;
    localparam logic [31:0] ADR_STAT_BASE  = 32'(2 + NUM_REGS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_ack;
    logic                r_int;
    logic [DW-1:0]       r_dat;
    logic [DW-1:0]       r_ctrl [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_stb;
    logic [NUM_INTS-1:0] r_int_status;
    logic [NUM_INTS-1:0] r_int_enable;
    logic [NUM_INTS-1:0] r_irq_prev;

    logic                w_access;
    logic                w_write;
    logic                w_hit_status;
    logic                w_hit_enable;
    logic [NUM_REGS-1:0] w_ctrl_hit;
    logic [NUM_REGS-1:0] w_stat_hit;
    logic [DW-1:0]       w_bmask;
    logic [DW-1:0]       w_wmask_dat;
    logic [DW-1:0]       w_rd_data;
    logic [NUM_INTS-1:0] w_int_clear;
    logic [NUM_INTS-1:0] w_irq_event;

    // An access happens only on the IDLE edge, so a held strobe is served once.
    assign w_access = (r_state == S_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign w_write  = w_access && wbs_we_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_hit_status = (wbs_adr_i == ADR_INT_STATUS);
        w_hit_enable = (wbs_adr_i == ADR_INT_ENABLE);
        w_ctrl_hit   = '0;
        w_stat_hit   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_ctrl_hit[k] = (wbs_adr_i == ADR_CTRL_BASE + 32'(k));
            w_stat_hit[k] = (wbs_adr_i == ADR_STAT_BASE + 32'(k));
        end
    end

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < NB; b++) begin
            w_bmask[b*8 +: 8] = {8{wbs_sel_i[b]}};
        end
    end

    assign w_wmask_dat = wbs_dat_i & w_bmask;
    assign w_int_clear = (w_write && w_hit_status) ? w_wmask_dat[NUM_INTS-1:0] : '0;
    assign w_irq_event = irq_i & ~r_irq_prev;

    // Unmapped addresses fall through to the all-zero default.
    always_comb begin
        w_rd_data = '0;
        if (w_hit_status) begin
            w_rd_data[NUM_INTS-1:0] = r_int_status;
        end
        if (w_hit_enable) begin
            w_rd_data[NUM_INTS-1:0] = r_int_enable;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_ctrl_hit[k]) begin
                w_rd_data = r_ctrl[k];
            end
            if (w_stat_hit[k]) begin
                w_rd_data = stat_i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ack        <= 1'b0;
            r_int        <= 1'b0;
            r_dat        <= '0;
            r_wr_stb     <= '0;
            r_int_status <= '0;
            r_int_enable <= '0;
            r_irq_prev   <= irq_i;
            // NOTE: the control array is a handful of flops feeding core logic, so it is reset like any register.
            for (int k = 0; k < NUM_REGS; k++) begin
                r_ctrl[k] <= '0;
            end
        end else begin
            r_irq_prev   <= irq_i;
            r_wr_stb     <= '0;
            r_int        <= |(r_int_status & r_int_enable);
            // Set after clear: a new event wins over a same-cycle W1C.
            r_int_status <= (r_int_status & ~w_int_clear) | w_irq_event;

            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                        if (wbs_we_i) begin
                            if (w_hit_enable) begin
                                r_int_enable <= (r_int_enable & ~w_bmask[NUM_INTS-1:0])
                                              | w_wmask_dat[NUM_INTS-1:0];
                            end
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (w_ctrl_hit[k]) begin
                                    r_ctrl[k] <= (r_ctrl[k] & ~w_bmask) | w_wmask_dat;
                                end
                            end
                            r_wr_stb <= w_ctrl_hit;
                        end else begin
                            r_dat <= w_rd_data;
                        end
                    end
                end
                S_ACK: begin
                    if (!(wbs_cyc_i && wbs_stb_i)) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl_out
        assign ctrl_o[k*DW +: DW] = r_ctrl[k];
    end

    assign wbs_dat_o = r_dat;
    assign wbs_ack_o = r_ack;
    assign wbs_int_o = r_int;
    assign wr_stb_o  = r_wr_stb;

endmodule

// File: tb/tb_wishbone_slave_regfile.sv
// Directed self-checking bench for wishbone_slave_regfile at default parameters
// (DW=32, NUM_REGS=4, NUM_INTS=8): map 0 INT_STATUS, 1 INT_ENABLE, 2..5 CTRL, 6..9 STAT.
module tb_wishbone_slave_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic         wbs_cyc_i;
    logic         wbs_stb_i;
    logic         wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i;
    logic [31:0]  wbs_dat_i;
    logic [31:0]  wbs_dat_o;
    logic         wbs_ack_o;
    logic         wbs_int_o;
    logic [127:0] ctrl_o;
    logic [3:0]   wr_stb_o;
    logic [127:0] stat_i;
    logic [7:0]   irq_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    wishbone_slave_regfile #(
        .DW       (32),
        .NUM_REGS (4),
        .NUM_INTS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_int_o (wbs_int_o),
        .ctrl_o    (ctrl_o),
        .wr_stb_o  (wr_stb_o),
        .stat_i    (stat_i),
        .irq_i     (irq_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tasks start and end #1 after a rising edge, a safe point to change inputs.
    task automatic wait_ack(input string tag);
        int edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!wbs_ack_o && edges < 20);
        check({tag, "_ack_latency"}, 128'(edges), 128'd1);
    endtask

    task automatic bus_idle(input string tag);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 128'(wbs_ack_o), 128'd0);
    endtask

    task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [3:0] stb_seen);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        wait_ack(tag);
        stb_seen = wr_stb_o;
        bus_idle(tag);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] adr, output logic [31:0] dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = adr;
        wbs_dat_i = 32'hDEAD_BEEF;
        wbs_sel_i = 4'hF;
        wait_ack(tag);
        dat = wbs_dat_o;
        bus_idle(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  stb_seen;
        int          pulses;
        int          ack_high;

        rst       = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        stat_i    = 128'd0;
        irq_i     = 8'hFF;

        // Reset with every interrupt source high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",    128'(wbs_ack_o), 128'd0);
        check("rst_int",    128'(wbs_int_o), 128'd0);
        check("rst_dat",    128'(wbs_dat_o), 128'd0);
        check("rst_ctrl",   ctrl_o,          128'd0);
        check("rst_wr_stb", 128'(wr_stb_o),  128'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_int", 128'(wbs_int_o), 128'd0);
        wb_read("post_rst_status", 32'd0, rd);
        check("post_rst_status_val", 128'(rd), 128'd0);
        wb_read("post_rst_enable", 32'd1, rd);
        check("post_rst_enable_val", 128'(rd), 128'd0);
        irq_i = 8'h00;

        // Byte-lane write to CTRL[1].
        wb_write("ctrl1_wr", 32'd3, 32'hAABB_CCDD, 4'b0101, stb_seen);
        check("ctrl1_wr_stb",      128'(stb_seen),  128'h2);
        check("ctrl1_wr_stb_gone", 128'(wr_stb_o),  128'h0);
        check("ctrl1_value",       ctrl_o,          {32'h0, 32'h0, 32'h00BB_00DD, 32'h0});
        check("dat_hold_on_write", 128'(wbs_dat_o), 128'h0);
        wb_read("ctrl1_rd", 32'd3, rd);
        check("ctrl1_rd_val", 128'(rd), 128'h00BB_00DD);

        // Held strobe on CTRL[2]: one access, ack for all five edges.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'd4;
        wbs_dat_i = 32'h1122_3344;
        wbs_sel_i = 4'hF;
        pulses    = 0;
        ack_high  = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (wr_stb_o[2]) pulses++;
            if (wbs_ack_o) ack_high++;
        end
        check("held_pulses",   128'(pulses),   128'd1);
        check("held_ack_high", 128'(ack_high), 128'd5);
        bus_idle("held");
        check("held_ctrl2", ctrl_o, {32'h0, 32'h1122_3344, 32'h00BB_00DD, 32'h0});

        // Interrupt path.
        wb_write("en_wr", 32'd1, 32'h0000_0005, 4'b0001, stb_seen);
        check("en_wr_no_stb", 128'(stb_seen), 128'h0);
        irq_i = 8'h03;
        @(posedge clk);
        #1;
        check("irq_int_not_yet", 128'(wbs_int_o), 128'd0);
        @(posedge clk);
        #1;
        check("irq_int_rise", 128'(wbs_int_o), 128'd1);
        irq_i = 8'h00;
        wb_read("irq_status", 32'd0, rd);
        check("irq_status_val", 128'(rd), 128'h03);
        wb_write("w1c_bit0", 32'd0, 32'h0000_0001, 4'b0001, stb_seen);
        check("w1c_int_fall", 128'(wbs_int_o), 128'd0);
        wb_read("w1c_status", 32'd0, rd);
        check("w1c_status_val", 128'(rd), 128'h02);

        // Set bit 2, then clear it in the same cycle as a new rising edge.
        irq_i = 8'h04;
        @(posedge clk);
        #1;
        irq_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("bit2_int", 128'(wbs_int_o), 128'd1);
        irq_i = 8'h04;
        wb_write("collide", 32'd0, 32'h0000_0004, 4'b0001, stb_seen);
        wb_read("collide_status", 32'd0, rd);
        check("collide_status_val", 128'(rd), 128'h06);
        check("collide_int", 128'(wbs_int_o), 128'd1);
        wb_write("clear_lane_off", 32'd0, 32'h0000_00FF, 4'b0010, stb_seen);
        wb_read("lane_off_status", 32'd0, rd);
        check("lane_off_status_val", 128'(rd), 128'h06);
        wb_write("clear_all", 32'd0, 32'h0000_00FF, 4'b0001, stb_seen);
        wb_read("clear_all_status", 32'd0, rd);
        check("clear_all_status_val", 128'(rd), 128'h00);
        check("clear_all_int", 128'(wbs_int_o), 128'd0);
        irq_i = 8'h00;

        // Map edges.
        stat_i = {32'h1234_5678, 32'h0BAD_F00D, 32'h5555_AAAA, 32'hCAFE_F00D};
        wb_read("stat3", 32'd9, rd);
        check("stat3_val", 128'(rd), 128'h1234_5678);
        wb_read("stat0", 32'd6, rd);
        check("stat0_val", 128'(rd), 128'hCAFE_F00D);
        wb_write("stat_wr", 32'd9, 32'hFFFF_FFFF, 4'hF, stb_seen);
        check("stat_wr_no_stb", 128'(stb_seen), 128'h0);
        check("stat_wr_ctrl",   ctrl_o, {32'h0, 32'h1122_3344, 32'h00BB_00DD, 32'h0});
        check("stat_wr_dat_hold", 128'(wbs_dat_o), 128'hCAFE_F00D);
        wb_read("stat3_again", 32'd9, rd);
        check("stat3_again_val", 128'(rd), 128'h1234_5678);
        wb_read("unmapped", 32'd10, rd);
        check("unmapped_val", 128'(rd), 128'h0);
        wb_write("ctrl0_sel0", 32'd2, 32'hFFFF_FFFF, 4'h0, stb_seen);
        check("ctrl0_sel0_stb",  128'(stb_seen), 128'h1);
        check("ctrl0_sel0_ctrl", ctrl_o, {32'h0, 32'h1122_3344, 32'h00BB_00DD, 32'h0});
        wb_write("en_all", 32'd1, 32'hFFFF_FFFF, 4'hF, stb_seen);
        wb_read("en_all_rd", 32'd1, rd);
        check("en_all_val", 128'(rd), 128'hFF);

        // Reset in the middle of a held access.
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'd5;
        wbs_dat_i = 32'h7777_7777;
        wbs_sel_i = 4'hF;
        wait_ack("mid_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ack",  128'(wbs_ack_o), 128'd0);
        check("mid_rst_ctrl", ctrl_o,          128'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
